// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS-subset control and hazard unit.
package pipe_ctrl_pkg;

  // Primary opcodes (InstrD[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (InstrD[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operand source select for the E-stage ALU inputs
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUOUTM = 2'b10
  } fwd_sel_e;

  // Decoded control bits of the instruction sitting in D
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
    logic       reg_dst;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_controller_main_decoder.sv
// Combinational D-stage decoder: Opcode/Funct -> control bundle and operand usage.
module main_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       uses_rs,
  output logic       uses_rt
);

  logic       r_valid;
  logic [2:0] r_alu;

  // R-type function decode; unknown functs are flagged so the whole word becomes a NOP
  always_comb begin
    r_valid = 1'b1;
    r_alu   = ALU_AND;
    case (funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_valid = 1'b0;
    endcase
  end

  // Main opcode decode; anything unrecognised falls through to the all-zero NOP
  always_comb begin
    ctrl    = CTRL_NOP;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (r_valid) begin
          ctrl.reg_write   = 1'b1;
          ctrl.reg_dst     = 1'b1;
          ctrl.alu_control = r_alu;
          uses_rs          = 1'b1;
          uses_rt          = 1'b1;
        end
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
        uses_rs          = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
        uses_rs          = 1'b1;
        uses_rt          = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        uses_rs          = 1'b1;
        uses_rt          = 1'b1;
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
        uses_rs          = 1'b1;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Control and hazard unit for a 5-stage MIPS-subset pipeline: carries decoded
// control through D->E->M->W, resolves load-use/branch/jump hazards, selects
// forwarding paths and keeps saturating stall/flush event counters.
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      Opcode,
  input  logic [5:0]      Funct,
  input  logic [RW-1:0]   RsD,
  input  logic [RW-1:0]   RtD,
  input  logic [RW-1:0]   RsE,
  input  logic [RW-1:0]   RtE,
  input  logic [RW-1:0]   WriteRegE,
  input  logic [RW-1:0]   WriteRegM,
  input  logic [RW-1:0]   WriteRegW,
  input  logic            ZeroM,
  output logic            RegDstE,
  output logic            ALUSrcB,
  output logic [2:0]      ALUControlE,
  output logic            MemWrite,
  output logic            MemToReg,
  output logic            RegWriteW,
  output logic            PCSrc,
  output logic            JumpC,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic [CNTW-1:0] StallCnt,
  output logic [CNTW-1:0] FlushCnt
);

  ctrl_t ctrl_dec;
  logic  uses_rs;
  logic  uses_rt;

  main_decoder u_main_decoder (
    .opcode  (Opcode),
    .funct   (Funct),
    .ctrl    (ctrl_dec),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt)
  );

  // The E-stage destination is not needed: a load's destination is always RtE.
  logic unused_write_reg_e;
  assign unused_write_reg_e = ^WriteRegE;

  // D->E register
  logic       reg_write_e_q,  reg_write_e_d;
  logic       mem_to_reg_e_q, mem_to_reg_e_d;
  logic       mem_write_e_q,  mem_write_e_d;
  logic       branch_e_q,     branch_e_d;
  logic [2:0] alu_control_e_q, alu_control_e_d;
  logic       alu_src_e_q,    alu_src_e_d;
  logic       reg_dst_e_q,    reg_dst_e_d;
  // E->M register
  logic       reg_write_m_q,  reg_write_m_d;
  logic       mem_to_reg_m_q, mem_to_reg_m_d;
  logic       mem_write_m_q,  mem_write_m_d;
  logic       branch_m_q,     branch_m_d;
  // M->W register
  logic       reg_write_w_q,  reg_write_w_d;
  logic       mem_to_reg_w_q, mem_to_reg_w_d;
  // Event counters
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

  logic     lw_hazard;
  logic     lw_stall;
  logic     pc_src;
  logic     jump_c;
  logic     flush_d;
  logic     flush_e;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  // Hazard resolution: reset silences everything, a taken branch beats a load-use stall,
  // and a jump only redirects when neither of those is in progress.
  always_comb begin
    lw_hazard = mem_to_reg_e_q & reg_write_e_q & (RtE != '0) &
                ((uses_rs & (RtE == RsD)) | (uses_rt & (RtE == RtD)));
    pc_src    = 1'b0;
    lw_stall  = 1'b0;
    jump_c    = 1'b0;
    if (!reset) begin
      pc_src   = branch_m_q & ZeroM;
      lw_stall = lw_hazard & ~pc_src;
      jump_c   = ctrl_dec.jump & ~lw_hazard & ~pc_src;
    end
    flush_d = pc_src | jump_c;
    flush_e = pc_src | lw_stall;
  end

  // Forwarding: the younger result in M wins over W; $0 is never forwarded.
  always_comb begin
    fwd_a = FWD_REGFILE;
    fwd_b = FWD_REGFILE;
    if (!reset) begin
      if (reg_write_m_q && (RsE != '0) && (RsE == WriteRegM)) begin
        fwd_a = FWD_ALUOUTM;
      end else if (reg_write_w_q && (RsE != '0) && (RsE == WriteRegW)) begin
        fwd_a = FWD_RESULTW;
      end
      if (reg_write_m_q && (RtE != '0) && (RtE == WriteRegM)) begin
        fwd_b = FWD_ALUOUTM;
      end else if (reg_write_w_q && (RtE != '0) && (RtE == WriteRegW)) begin
        fwd_b = FWD_RESULTW;
      end
    end
  end

  // Next values of the pipeline control registers and counters
  always_comb begin
    reg_write_e_d   = ctrl_dec.reg_write;
    mem_to_reg_e_d  = ctrl_dec.mem_to_reg;
    mem_write_e_d   = ctrl_dec.mem_write;
    branch_e_d      = ctrl_dec.branch;
    alu_control_e_d = ctrl_dec.alu_control;
    alu_src_e_d     = ctrl_dec.alu_src;
    reg_dst_e_d     = ctrl_dec.reg_dst;
    if (flush_e) begin
      reg_write_e_d   = 1'b0;
      mem_to_reg_e_d  = 1'b0;
      mem_write_e_d   = 1'b0;
      branch_e_d      = 1'b0;
      alu_control_e_d = 3'b000;
      alu_src_e_d     = 1'b0;
      reg_dst_e_d     = 1'b0;
    end

    reg_write_m_d  = reg_write_e_q;
    mem_to_reg_m_d = mem_to_reg_e_q;
    mem_write_m_d  = mem_write_e_q;
    branch_m_d     = branch_e_q;
    if (pc_src) begin
      // The instruction behind a taken branch must not reach memory.
      reg_write_m_d  = 1'b0;
      mem_to_reg_m_d = 1'b0;
      mem_write_m_d  = 1'b0;
      branch_m_d     = 1'b0;
    end

    reg_write_w_d  = reg_write_m_q;
    mem_to_reg_w_d = mem_to_reg_m_q;

    stall_cnt_d = stall_cnt_q;
    if (lw_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if ((pc_src || jump_c) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNTW'(1);
    end
  end

  // State register with synchronous reset to an all-bubble pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_e_q   <= 1'b0;
      mem_to_reg_e_q  <= 1'b0;
      mem_write_e_q   <= 1'b0;
      branch_e_q      <= 1'b0;
      alu_control_e_q <= 3'b000;
      alu_src_e_q     <= 1'b0;
      reg_dst_e_q     <= 1'b0;
      reg_write_m_q   <= 1'b0;
      mem_to_reg_m_q  <= 1'b0;
      mem_write_m_q   <= 1'b0;
      branch_m_q      <= 1'b0;
      reg_write_w_q   <= 1'b0;
      mem_to_reg_w_q  <= 1'b0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      reg_write_e_q   <= reg_write_e_d;
      mem_to_reg_e_q  <= mem_to_reg_e_d;
      mem_write_e_q   <= mem_write_e_d;
      branch_e_q      <= branch_e_d;
      alu_control_e_q <= alu_control_e_d;
      alu_src_e_q     <= alu_src_e_d;
      reg_dst_e_q     <= reg_dst_e_d;
      reg_write_m_q   <= reg_write_m_d;
      mem_to_reg_m_q  <= mem_to_reg_m_d;
      mem_write_m_q   <= mem_write_m_d;
      branch_m_q      <= branch_m_d;
      reg_write_w_q   <= reg_write_w_d;
      mem_to_reg_w_q  <= mem_to_reg_w_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign RegDstE     = reg_dst_e_q;
  assign ALUSrcB     = alu_src_e_q;
  assign ALUControlE = alu_control_e_q;
  assign MemWrite    = mem_write_m_q & ~reset;
  assign MemToReg    = mem_to_reg_w_q;
  assign RegWriteW   = reg_write_w_q;
  assign PCSrc       = pc_src;
  assign JumpC       = jump_c;
  assign StallF      = lw_stall;
  assign StallD      = lw_stall;
  assign FlushD      = flush_d;
  assign FlushE      = flush_e;
  assign ForwardAE   = fwd_a;
  assign ForwardBE   = fwd_b;
  assign StallCnt    = stall_cnt_q;
  assign FlushCnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: walks short instruction sequences through
// the pipeline by driving the stage specifiers a datapath would present.
module tb_pipe_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        ZeroM;
  logic        RegDstE, ALUSrcB, MemWrite, MemToReg, RegWriteW, PCSrc, JumpC;
  logic        StallF, StallD, FlushD, FlushE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCnt, FlushCnt;

  int total = 0;
  int bad   = 0;

  pipe_controller #(.RW(5), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .ZeroM(ZeroM), .RegDstE(RegDstE), .ALUSrcB(ALUSrcB), .ALUControlE(ALUControlE),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWriteW(RegWriteW),
    .PCSrc(PCSrc), .JumpC(JumpC), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Opcode = 6'b0; Funct = 6'b0; RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
    WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0; ZeroM = 1'b0;
  endtask

  task automatic set_d(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt);
    Opcode = op; Funct = fn; RsD = rs; RtD = rt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    set_d(6'b100011, 6'b0, 5'd2, 5'd2);
    RsE = 5'd2; RtE = 5'd2; WriteRegM = 5'd2; WriteRegW = 5'd2; ZeroM = 1'b1;
    step();
    step();
    #1;
    total++;
    if ({RegDstE, ALUSrcB, ALUControlE, MemWrite, MemToReg, RegWriteW} !== 8'b0) begin
      bad++; $display("FAIL reset_datapath_ctrl got=%b exp=0",
                      {RegDstE, ALUSrcB, ALUControlE, MemWrite, MemToReg, RegWriteW});
    end
    total++;
    if ({PCSrc, JumpC, StallF, StallD, FlushD, FlushE} !== 6'b0) begin
      bad++; $display("FAIL reset_hazard got=%b exp=0",
                      {PCSrc, JumpC, StallF, StallD, FlushD, FlushE});
    end
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0) begin
      bad++; $display("FAIL reset_forward got=%b exp=0", {ForwardAE, ForwardBE});
    end
    total++;
    if ({StallCnt, FlushCnt} !== 32'h0) begin
      bad++; $display("FAIL reset_counters got=%h exp=0", {StallCnt, FlushCnt});
    end
    // Leaving reset with lw in D: it must now appear in E.
    reset = 1'b0;
    ZeroM = 1'b0;
    step();
    total++;
    if (ALUSrcB !== 1'b1) begin
      bad++; $display("FAIL reset_release_lw_in_e got=%b exp=1", ALUSrcB);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    set_d(6'b000000, 6'b100000, 5'd1, 5'd2);   // add $3,$1,$2
    step();
    set_d(6'b000000, 6'b100010, 5'd3, 5'd1);   // sub $4,$3,$1
    RsE = 5'd1; RtE = 5'd2;
    #1;
    total++;
    if ({RegDstE, ALUControlE, ALUSrcB} !== 5'b1_010_0) begin
      bad++; $display("FAIL fwd_add_in_e got=%b exp=10100", {RegDstE, ALUControlE, ALUSrcB});
    end
    step();
    set_d(6'b000000, 6'b100100, 5'd3, 5'd6);   // and $5,$3,$6
    RsE = 5'd3; RtE = 5'd1; WriteRegM = 5'd3; WriteRegW = 5'd0;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b10_00) begin
      bad++; $display("FAIL fwd_sub_from_m got=%b exp=1000", {ForwardAE, ForwardBE});
    end
    total++;
    if (ALUControlE !== 3'b110) begin
      bad++; $display("FAIL fwd_sub_aluctl got=%b exp=110", ALUControlE);
    end
    step();
    set_d(6'b000000, 6'b000000, 5'd0, 5'd0);
    RsE = 5'd3; RtE = 5'd4; WriteRegM = 5'd4; WriteRegW = 5'd3;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b01_10) begin
      bad++; $display("FAIL fwd_and_w_and_m got=%b exp=0110", {ForwardAE, ForwardBE});
    end
    total++;
    if ({RegWriteW, MemToReg, ALUControlE} !== 5'b1_0_000) begin
      bad++; $display("FAIL fwd_add_in_w got=%b exp=10000", {RegWriteW, MemToReg, ALUControlE});
    end
    WriteRegM = 5'd3;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b10_00) begin
      bad++; $display("FAIL fwd_m_beats_w got=%b exp=1000", {ForwardAE, ForwardBE});
    end
  endtask

  task automatic test_lw_stall();
    do_reset();
    set_d(6'b100011, 6'b0, 5'd0, 5'd2);        // lw $2,0($0)
    step();
    set_d(6'b000000, 6'b100000, 5'd2, 5'd5);   // add $4,$2,$5
    RtE = 5'd2;
    #1;
    total++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
      bad++; $display("FAIL lw_stall_active got=%b exp=1110", {StallF, StallD, FlushE, FlushD});
    end
    step();
    RtE = 5'd0;
    #1;
    total++;
    if ({StallF, FlushE, ALUSrcB} !== 3'b000 || StallCnt !== 16'd1) begin
      bad++; $display("FAIL lw_stall_bubble got=%b cnt=%0d exp=000 cnt=1",
                      {StallF, FlushE, ALUSrcB}, StallCnt);
    end
    step();
    RsE = 5'd2; RtE = 5'd5; WriteRegW = 5'd2;
    #1;
    total++;
    if ({ForwardAE, ForwardBE, MemToReg, RegWriteW} !== 6'b01_00_1_1 || StallCnt !== 16'd1) begin
      bad++; $display("FAIL lw_stall_resume got=%b cnt=%0d exp=010011 cnt=1",
                      {ForwardAE, ForwardBE, MemToReg, RegWriteW}, StallCnt);
    end
    // addi writes Rt rather than reading it, so a match on Rt alone is no hazard.
    do_reset();
    set_d(6'b100011, 6'b0, 5'd0, 5'd2);
    step();
    set_d(6'b001000, 6'b0, 5'd3, 5'd2);        // addi $2,$3,imm
    RtE = 5'd2;
    #1;
    total++;
    if ({StallF, FlushE} !== 2'b00) begin
      bad++; $display("FAIL lw_addi_no_stall got=%b exp=00", {StallF, FlushE});
    end
  endtask

  task automatic test_branch();
    // Not taken: the store behind beq reaches M.
    do_reset();
    set_d(6'b000100, 6'b0, 5'd1, 5'd2);
    step();
    set_d(6'b101011, 6'b0, 5'd0, 5'd7);
    #1;
    total++;
    if (ALUControlE !== 3'b110) begin
      bad++; $display("FAIL beq_aluctl got=%b exp=110", ALUControlE);
    end
    step();
    set_d(6'b0, 6'b0, 5'd0, 5'd0);
    #1;
    total++;
    if ({PCSrc, FlushD} !== 2'b00) begin
      bad++; $display("FAIL beq_not_taken got=%b exp=00", {PCSrc, FlushD});
    end
    step();
    total++;
    if (MemWrite !== 1'b1 || FlushCnt !== 16'd0) begin
      bad++; $display("FAIL beq_nt_store got=%b cnt=%0d exp=1 cnt=0", MemWrite, FlushCnt);
    end
    // Taken while a load-use hazard is also present.
    do_reset();
    set_d(6'b000100, 6'b0, 5'd1, 5'd2);
    step();
    set_d(6'b100011, 6'b0, 5'd0, 5'd7);
    step();
    set_d(6'b101011, 6'b0, 5'd0, 5'd7);
    RtE = 5'd7; ZeroM = 1'b1;
    #1;
    total++;
    if ({PCSrc, FlushD, FlushE, StallF, StallD} !== 5'b11100) begin
      bad++; $display("FAIL beq_taken_over_lw got=%b exp=11100",
                      {PCSrc, FlushD, FlushE, StallF, StallD});
    end
    step();
    ZeroM = 1'b0; RtE = 5'd0;
    set_d(6'b0, 6'b0, 5'd0, 5'd0);
    #1;
    total++;
    if (PCSrc !== 1'b0 || FlushCnt !== 16'd1 || StallCnt !== 16'd0) begin
      bad++; $display("FAIL beq_taken_counts got=%b fc=%0d sc=%0d exp=0 fc=1 sc=0",
                      PCSrc, FlushCnt, StallCnt);
    end
    // Taken with a store right behind: the store is squashed before M.
    do_reset();
    set_d(6'b000100, 6'b0, 5'd1, 5'd2);
    step();
    set_d(6'b101011, 6'b0, 5'd0, 5'd7);
    step();
    set_d(6'b0, 6'b0, 5'd0, 5'd0);
    ZeroM = 1'b1;
    #1;
    total++;
    if (PCSrc !== 1'b1) begin
      bad++; $display("FAIL beq_taken_pcsrc got=%b exp=1", PCSrc);
    end
    step();
    ZeroM = 1'b0;
    #1;
    total++;
    if (MemWrite !== 1'b0 || FlushCnt !== 16'd1) begin
      bad++; $display("FAIL beq_store_squashed got=%b cnt=%0d exp=0 cnt=1", MemWrite, FlushCnt);
    end
  endtask

  task automatic test_jump();
    do_reset();
    set_d(6'b000010, 6'b0, 5'd0, 5'd0);
    #1;
    total++;
    if ({JumpC, FlushD, FlushE, StallF} !== 4'b1100) begin
      bad++; $display("FAIL jump_redirect got=%b exp=1100", {JumpC, FlushD, FlushE, StallF});
    end
    step();
    set_d(6'b0, 6'b0, 5'd0, 5'd0);
    #1;
    total++;
    if ({JumpC, FlushD} !== 2'b00 || FlushCnt !== 16'd1) begin
      bad++; $display("FAIL jump_one_bubble got=%b cnt=%0d exp=00 cnt=1", {JumpC, FlushD}, FlushCnt);
    end
    // A taken branch in M suppresses a jump in D.
    do_reset();
    set_d(6'b000100, 6'b0, 5'd1, 5'd2);
    step();
    set_d(6'b0, 6'b0, 5'd0, 5'd0);
    step();
    set_d(6'b000010, 6'b0, 5'd0, 5'd0);
    ZeroM = 1'b1;
    #1;
    total++;
    if ({JumpC, PCSrc, FlushD} !== 3'b011) begin
      bad++; $display("FAIL jump_under_branch got=%b exp=011", {JumpC, PCSrc, FlushD});
    end
    step();
    ZeroM = 1'b0;
    #1;
    total++;
    if (JumpC !== 1'b1 || FlushCnt !== 16'd1) begin
      bad++; $display("FAIL jump_after_branch got=%b cnt=%0d exp=1 cnt=1", JumpC, FlushCnt);
    end
    step();
    set_d(6'b0, 6'b0, 5'd0, 5'd0);
    #1;
    total++;
    if (FlushCnt !== 16'd2) begin
      bad++; $display("FAIL jump_flush_count got=%0d exp=2", FlushCnt);
    end
  endtask

  task automatic test_undefined();
    do_reset();
    set_d(6'b111111, 6'b100000, 5'd1, 5'd2);
    #1;
    total++;
    if ({JumpC, StallF} !== 2'b00) begin
      bad++; $display("FAIL undef_op_d got=%b exp=00", {JumpC, StallF});
    end
    step();
    set_d(6'b000000, 6'b111111, 5'd1, 5'd2);  // R-type with unknown funct
    #1;
    total++;
    if ({RegDstE, ALUControlE, ALUSrcB} !== 5'b0) begin
      bad++; $display("FAIL undef_op_e got=%b exp=00000", {RegDstE, ALUControlE, ALUSrcB});
    end
    step();
    set_d(6'b000000, 6'b100000, 5'd1, 5'd2);  // add $0,$1,$2
    #1;
    total++;
    if (MemWrite !== 1'b0 || RegDstE !== 1'b0) begin
      bad++; $display("FAIL undef_op_m got=%b%b exp=00", MemWrite, RegDstE);
    end
    step();
    set_d(6'b0, 6'b0, 5'd0, 5'd0);
    #1;
    total++;
    if ({RegWriteW, MemToReg, RegDstE} !== 3'b001) begin
      bad++; $display("FAIL undef_op_w got=%b exp=001", {RegWriteW, MemToReg, RegDstE});
    end
    step();
    RsE = 5'd0; RtE = 5'd0; WriteRegM = 5'd0;
    #1;
    total++;
    if ({ForwardAE, ForwardBE, RegWriteW} !== 5'b00_00_0) begin
      bad++; $display("FAIL zero_reg_no_fwd_m got=%b exp=00000", {ForwardAE, ForwardBE, RegWriteW});
    end
    step();
    WriteRegM = 5'd9; WriteRegW = 5'd0;
    #1;
    total++;
    if ({ForwardAE, ForwardBE, RegWriteW} !== 5'b00_00_1) begin
      bad++; $display("FAIL zero_reg_no_fwd_w got=%b exp=00001", {ForwardAE, ForwardBE, RegWriteW});
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_lw_stall();
    test_branch();
    test_jump();
    test_undefined();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
